// File: rtl/pc_ras_if.sv
// Fetch-stage PC bundle: control/operand inputs from decode and the PC, link and RAS status back.
interface pc_ras_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             exc;
  logic             branch_en;
  logic [2:0]       branch_cond;
  logic             zeroflag;
  logic             negflag;
  logic [15:0]      branch_imm;
  logic             jmp_en;
  logic [25:0]      jmp_index;
  logic             link;
  logic             jr_en;
  logic [WIDTH-1:0] jr_address;
  logic             ret;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] link_address;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_overflow;
  logic             ras_mispredict;

  modport master (
    output stall, exc, branch_en, branch_cond, zeroflag, negflag, branch_imm,
           jmp_en, jmp_index, link, jr_en, jr_address, ret,
    input  out, link_address, ras_empty, ras_full, ras_overflow, ras_mispredict
  );

  modport slave (
    input  stall, exc, branch_en, branch_cond, zeroflag, negflag, branch_imm,
           jmp_en, jmp_index, link, jr_en, jr_address, ret,
    output out, link_address, ras_empty, ras_full, ras_overflow, ras_mispredict
  );
endinterface

// File: rtl/pc_ras.sv
// Program counter with stall, exception vector, MIPS branches/jumps and a circular return-address stack.
// One cycle from controls to out; link_address is out+4 combinationally; stall freezes PC and RAS.
module pc_ras #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h80),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_ras_if.slave  bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             mis_q, mis_d;
  logic             push;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] pc4, boff, btarget, jtarget, ras_top;
  logic             full, taken;

  assign pc4     = pc_q + WIDTH'(4);
  assign boff    = {{(WIDTH-18){bus.branch_imm[15]}}, bus.branch_imm, 2'b00};
  assign btarget = pc4 + boff;
  assign full    = (cnt_q == CW'(RAS_DEPTH));
  assign ras_top = ras_q[ptr_q - PW'(1)];

  // The region bits above the 28-bit jump span only exist for wider datapaths.
  if (WIDTH > 28) begin : g_jhi
    assign jtarget = {pc4[WIDTH-1:28], bus.jmp_index, 2'b00};
  end else begin : g_jlo
    assign jtarget = {bus.jmp_index, 2'b00};
  end

  always_comb begin
    taken = 1'b0;
    case (bus.branch_cond)
      3'd0:    taken = bus.zeroflag;
      3'd1:    taken = !bus.zeroflag;
      3'd2:    taken = bus.negflag;
      3'd3:    taken = !bus.negflag;
      3'd4:    taken = bus.negflag | bus.zeroflag;
      3'd5:    taken = !bus.negflag & !bus.zeroflag;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    mis_d = 1'b0;
    push  = 1'b0;
    if (bus.exc) begin
      pc_d = EXC_VECTOR;
    end else if (!bus.stall) begin
      if (bus.jr_en) begin
        pc_d = bus.jr_address;
        if (bus.ret) begin
          if (cnt_q == '0) begin
            mis_d = 1'b1;
          end else begin
            mis_d = (ras_top != bus.jr_address);
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
          end
        end
      end else if (bus.jmp_en) begin
        pc_d = jtarget;
        if (bus.link) begin
          push  = 1'b1;
          ptr_d = ptr_q + PW'(1);
          // A full stack keeps its count; the new entry lands on the oldest slot.
          if (full) ovf_d = 1'b1;
          else      cnt_d = cnt_q + CW'(1);
        end
      end else if (bus.branch_en && taken) begin
        pc_d = btarget;
      end else begin
        pc_d = pc4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      mis_q <= mis_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) ras_q[ptr_q] <= pc4;
  end

  assign bus.out            = pc_q;
  assign bus.link_address   = pc4;
  assign bus.ras_empty      = (cnt_q == '0);
  assign bus.ras_full       = full;
  assign bus.ras_overflow   = ovf_q;
  assign bus.ras_mispredict = mis_q;
endmodule

// File: tb/tb_pc_ras.sv
// Bench for pc_ras: directed scenarios with literal expectations, then random traffic against a queue-based model.
module tb_pc_ras;
  localparam int          WIDTH = 32;
  localparam int          DEPTH = 4;
  localparam int unsigned RV    = 32'h0;
  localparam int unsigned EV    = 32'h80;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_ras_if #(.WIDTH(WIDTH)) bus ();

  pc_ras #(
    .WIDTH(WIDTH), .RESET_VECTOR(RV), .EXC_VECTOR(EV), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model: PC as a number, RAS as a bounded queue (oldest at front).
  int unsigned m_pc = 0;
  int unsigned m_ras[$];
  bit          m_ovf = 1'b0;
  bit          m_mis = 1'b0;

  function automatic bit cond_true(int c, bit z, bit n);
    case (c)
      0: return z;
      1: return !z;
      2: return n;
      3: return !n;
      4: return n || z;
      5: return !n && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int unsigned pc4, off;
    if (rst) begin
      m_pc = RV; m_ras.delete(); m_ovf = 1'b0; m_mis = 1'b0;
    end else if (bus.exc) begin
      m_pc = EV; m_mis = 1'b0;
    end else if (bus.stall) begin
      m_mis = 1'b0;
    end else begin
      pc4   = m_pc + 4;
      m_mis = 1'b0;
      if (bus.jr_en) begin
        if (bus.ret) begin
          if (m_ras.size() == 0) m_mis = 1'b1;
          else                   m_mis = (m_ras.pop_back() != bus.jr_address);
        end
        m_pc = bus.jr_address;
      end else if (bus.jmp_en) begin
        if (bus.link) begin
          if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_ras.push_back(pc4);
        end
        m_pc = (pc4 & 32'hF000_0000) | (int'(bus.jmp_index) * 4);
      end else if (bus.branch_en && cond_true(int'(bus.branch_cond), bus.zeroflag, bus.negflag)) begin
        off  = {{16{bus.branch_imm[15]}}, bus.branch_imm};
        m_pc = pc4 + off * 4;
      end else begin
        m_pc = pc4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out",            bus.out,            m_pc);
      chk("link_address",   bus.link_address,   m_pc + 32'd4);
      chk("ras_empty",      bus.ras_empty,      m_ras.size() == 0);
      chk("ras_full",       bus.ras_full,       m_ras.size() == DEPTH);
      chk("ras_overflow",   bus.ras_overflow,   m_ovf);
      chk("ras_mispredict", bus.ras_mispredict, m_mis);
    end
  end

  task automatic idle();
    bus.stall = 0; bus.exc = 0; bus.branch_en = 0; bus.branch_cond = 0;
    bus.zeroflag = 0; bus.negflag = 0; bus.branch_imm = 0; bus.jmp_en = 0;
    bus.jmp_index = 0; bus.link = 0; bus.jr_en = 0; bus.jr_address = 0; bus.ret = 0;
    rst = 0;
  endtask

  task automatic go();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic set_pc(int unsigned a);
    bus.jr_en = 1; bus.jr_address = a;
    go();
  endtask

  task automatic branch(int c, bit z, bit n);
    set_pc(32'h100);
    bus.branch_en = 1; bus.branch_cond = 3'(c); bus.zeroflag = z; bus.negflag = n;
    bus.branch_imm = 16'hFFFC;
    go();
  endtask

  task automatic jal_from(int unsigned a);
    set_pc(a);
    bus.jmp_en = 1; bus.link = 1; bus.jmp_index = 26'h40;
    go();
  endtask

  task automatic pop(int unsigned a);
    bus.jr_en = 1; bus.ret = 1; bus.jr_address = a;
    go();
  endtask

  initial begin
    idle();
    @(negedge clk);
    rst = 1;
    go();
    chk_en = 1;
    rst = 1;
    go();
    chk("rst_out", bus.out, 32'h0);
    chk("rst_empty", bus.ras_empty, 1);
    go(); chk("seq4", bus.out, 32'h4);
    go(); chk("seq8", bus.out, 32'h8);
    go(); chk("seq12", bus.out, 32'hC);

    branch(1, 0, 0); chk("bne_taken", bus.out, 32'hF4);
    branch(0, 0, 0); chk("beq_nt", bus.out, 32'h104);
    branch(5, 0, 1); chk("bgtz_nt", bus.out, 32'h104);
    branch(6, 1, 1); chk("cond6_nt", bus.out, 32'h104);
    branch(4, 1, 0); chk("blez_taken", bus.out, 32'hF4);

    jal_from(32'h200);
    chk("jal_out", bus.out, 32'h100);
    chk("jal_nonempty", bus.ras_empty, 0);
    pop(32'h204);
    chk("ret_out", bus.out, 32'h204);
    chk("ret_mis0", bus.ras_mispredict, 0);
    chk("ret_empty", bus.ras_empty, 1);
    pop(32'h300);
    chk("ret2_out", bus.out, 32'h300);
    chk("ret2_mis1", bus.ras_mispredict, 1);

    for (int i = 1; i <= 5; i++) jal_from(32'h10 * i);
    chk("ovf_full", bus.ras_full, 1);
    chk("ovf_flag", bus.ras_overflow, 1);
    for (int i = 5; i >= 2; i--) begin
      pop(32'h10 * i + 4);
      chk("ovf_pop_mis", bus.ras_mispredict, 0);
    end
    chk("ovf_drained", bus.ras_empty, 1);
    pop(32'h24);
    chk("ovf_empty_pop", bus.ras_mispredict, 1);

    set_pc(32'h100);
    bus.stall = 1; bus.jmp_en = 1; bus.link = 1; bus.jmp_index = 26'h3;
    go();
    chk("stall_out", bus.out, 32'h100);
    chk("stall_empty", bus.ras_empty, 1);
    bus.stall = 1; bus.exc = 1;
    go();
    chk("exc_out", bus.out, 32'h80);
    bus.jr_en = 1; bus.jr_address = 32'h340; bus.jmp_en = 1; bus.link = 1;
    go();
    chk("jr_jmp_out", bus.out, 32'h340);
    chk("jr_jmp_nopush", bus.ras_empty, 1);

    jal_from(32'h500);
    jal_from(32'h600);
    bus.jr_en = 1; bus.ret = 1; bus.jr_address = 32'h604; rst = 1;
    go();
    chk("mrst_out", bus.out, RV);
    chk("mrst_empty", bus.ras_empty, 1);
    chk("mrst_ovf", bus.ras_overflow, 0);
    pop(32'h504);
    chk("mrst_first_pop", bus.ras_mispredict, 1);

    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(99) == 0);
      bus.exc    = ($urandom_range(99) < 3);
      bus.stall  = ($urandom_range(99) < 15);
      bus.jr_en  = ($urandom_range(99) < 20);
      bus.ret    = ($urandom_range(99) < 70);
      if (m_ras.size() > 0 && $urandom_range(99) < 60) bus.jr_address = m_ras[m_ras.size() - 1];
      else bus.jr_address = $urandom() & 32'hFFFF_FFFC;
      bus.jmp_en      = ($urandom_range(99) < 25);
      bus.link        = ($urandom_range(99) < 60);
      bus.jmp_index   = 26'($urandom());
      bus.branch_en   = ($urandom_range(99) < 40);
      bus.branch_cond = 3'($urandom());
      bus.zeroflag    = 1'($urandom());
      bus.negflag     = 1'($urandom());
      bus.branch_imm  = 16'($urandom());
      go();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pc_ras.md
Name: pc_ras

Overview:
- Parametrised next-generation program counter for the MIPS CPU; replaces the single-mode PC register in the fetch stage.
- Adds the following:
  - stall hold
  - exception vectoring
  - six MIPS branch conditions
  - J/JAL/JR with PC-relative link generation
  - circular return-address stack (RAS) for predicting JR $ra targets
- Outputs the fetch address and the link address to the register file.

Parameters:
- WIDTH, 32, PC/datapath width in bits; must be at least 28.
- RESET_VECTOR, 0, PC value loaded on reset.
- EXC_VECTOR, 32'h80, PC value loaded on exception (truncated to WIDTH).
- RAS_DEPTH, 4, number of return-address stack entries; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and RAS unchanged.
- exc  in  1  exception: load EXC_VECTOR.
- branch_en  in  1  conditional branch in current instruction.
- branch_cond  in  3  0=BEQ, 1=BNE, 2=BLTZ, 3=BGEZ, 4=BLEZ, 5=BGTZ; 6 and 7 are never taken.
- zeroflag  in  1  ALU result == 0.
- negflag  in  1  ALU result < 0 (signed).
- branch_imm  in  16  raw signed word offset from the instruction.
- jmp_en  in  1  J or JAL.
- jmp_index  in  26  instruction index.
- link  in  1  with jmp_en: JAL (push return address).
- jr_en  in  1  JR.
- jr_address  in  WIDTH  register value for JR.
- ret  in  1  with jr_en: JR $ra (pop RAS).
- out  out  WIDTH  current PC.
- link_address  out  WIDTH  out+4, combinational.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.
- ras_overflow  out  1  sticky: a push occurred while full.
- ras_mispredict  out  1  registered one-cycle pulse: a pop target differed from jr_address, or a pop hit an empty RAS.

Behaviour:
- Reset (rst=1 at posedge): out=RESET_VECTOR, RAS count=0, RAS pointer=0, ras_overflow=0, ras_mispredict=0. RAS entry contents are don't-care. rst overrides every other input.
- Arithmetic is modulo 2^WIDTH with no carry out.
  - pc4 = out+4
  - btarget = pc4 + (sign-extend(branch_imm) << 2)
  - jtarget = {pc4[WIDTH-1:28], jmp_index, 2'b00}
- Next-PC priority at posedge, highest first:
  1. rst
  2. exc: out=EXC_VECTOR; RAS untouched; overrides stall.
  3. stall: out, RAS and ras_overflow hold; ras_mispredict clears to 0.
  4. jr_en: out=jr_address (architectural target always used).
  5. jmp_en: out=jtarget.
  6. branch_en with condition true: out=btarget.
  7. Otherwise, including a branch not taken: out=pc4.
- Condition truth per branch_cond:
  - BEQ: zeroflag
  - BNE: !zeroflag
  - BLTZ: negflag
  - BGEZ: !negflag
  - BLEZ: negflag | zeroflag
  - BGTZ: !negflag & !zeroflag
- Controls asserted together: resolved strictly by priority. Lower-priority controls have no side effects; e.g. jr_en+jmp_en+link performs no push.
- RAS push occurs when jmp_en & link is the selected action (not stalled, no exc):
  - entry[ptr] <= pc4; ptr <= ptr+1 (wraps mod RAS_DEPTH).
  - If count < RAS_DEPTH: count++.
  - If full: count stays; the oldest entry is overwritten (circular); ras_overflow <= 1.
- RAS pop occurs when jr_en & ret is the selected action:
  - If count > 0: compare entry[ptr-1] with jr_address; ras_mispredict <= (unequal); ptr--, count--.
  - If count == 0: ras_mispredict <= 1; ptr and count unchanged.
- ras_mispredict is 0 on every non-pop, non-stalled cycle.
- jr_en without ret: no RAS activity.
- ras_overflow clears only on rst.
- Reset mid-sequence discards all RAS contents. The first pop after reset reports a mispredict.
- Latency: one cycle from control inputs to the out update. link_address follows out combinationally.

Test Plan:
- Reset: rst=1 for 2 cycles, RESET_VECTOR=0 -> out=0, ras_empty=1; release -> out=4, 8, 12 on successive cycles.
- Branches at out=0x100, branch_imm=16'hFFFC:
  - BNE with zeroflag=0 -> out=0xF4.
  - BEQ with zeroflag=0 -> out=0x104.
  - BGTZ with negflag=1 -> out=0x104.
  - branch_cond=6 -> out=0x104.
- Calls and returns: JAL at 0x200 (jmp_index=0x40) -> out=0x100, RAS holds 0x204. JR ret with jr_address=0x204 -> out=0x204, ras_mispredict=0 next cycle, ras_empty=1. A second JR ret (jr_address=0x300) -> out=0x300, ras_mispredict=1.
- Overflow: RAS_DEPTH=4, five JALs from 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_full=1, ras_overflow=1. Pops must return 0x54, 0x44, 0x34, 0x24, then report empty.
- Stall and exception: stall=1 with jmp_en+link -> out and RAS count unchanged. exc=1 with stall=1 -> out=0x80. jr_en and jmp_en together -> out=jr_address, no push.
- Mid-stream reset: rst during a pending JR ret with 2 RAS entries -> out=RESET_VECTOR, ras_empty=1, ras_overflow=0.
